// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and frame geometry for the FIFO-fed UART transmitter.
// FIFO_UART_TX_PARITY_EN adds the even-parity bit to every frame.
package fifo_uart_tx_pkg;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_t;

   localparam int DATA_WIDTH = 8;

   // start + data + [parity] + stop
   function automatic int frame_bits(input int width);
`ifdef FIFO_UART_TX_PARITY_EN
      return width + 3;
`else
      return width + 2;
`endif
   endfunction

   localparam int FRAME_BITS = frame_bits(DATA_WIDTH);

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle: head word, occupancy and pop strobe.
// master = FIFO side, slave = the single reader.
interface fifo_uart_tx_if #(
   parameter int WIDTH  = 8,
   parameter int SIZE_W = 4
);
   logic [WIDTH-1:0]  fifo_data;
   logic [SIZE_W-1:0] fifo_size;
   logic              fifo_get;

   modport master (output fifo_data, output fifo_size, input fifo_get);
   modport slave  (input fifo_data, input fifo_size, output fifo_get);
endinterface

// File: rtl/fifo.sv
// Generic circular FIFO; head word visible on data_o, size_o is occupancy, 1-cycle write/pop.
// Writes while full are dropped unless a pop happens on the same edge; pops while empty are ignored.
module fifo #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 4,
   parameter int SIZE_W = $clog2(DEPTH) + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [WIDTH-1:0]  data_i,
   input  logic              putData_i,
   output logic [WIDTH-1:0]  data_o,
   output logic [SIZE_W-1:0] size_o,
   input  logic              getData_i
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [SIZE_W-1:0] size_q;
   logic              do_get, do_put;

   assign do_get = getData_i && (size_q != '0);
   assign do_put = putData_i && ((size_q != SIZE_W'(DEPTH)) || do_get);

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk_i) begin
      if (do_put) mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         size_q   <= '0;
      end else begin
         if (do_put) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_get) rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (do_put && !do_get)      size_q <= size_q + 1'b1;
         else if (do_get && !do_put) size_q <= size_q - 1'b1;
      end
   end

   assign data_o = mem_q[rd_ptr_q];
   assign size_o = size_q;

endmodule

// File: rtl/fifo_uart_tx_baud_gen.sv
// Bit-time divider: tick_o pulses on the last cycle of every CLKS_PER_BIT-cycle bit time.
// clear_i holds the count at zero so a new frame starts on a fresh bit boundary.
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   output logic tick_o
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear_i || (cnt_q == LAST)) cnt_d = '0;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO reader + UART serialiser (8N1, 8E1 with FIFO_UART_TX_PARITY_EN); tx falls 1 clk after a word is seen.
// Pops only when enable_i and FIFO non-empty; a started frame always completes, back-to-back frames have no gap.
module fifo_uart_tx
   import fifo_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int WIDTH        = 8,
   parameter int SIZE_W       = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          enable_i,
   fifo_uart_tx_if.slave rd,
   output logic          tx_o,
   output logic          busy_o
);
   localparam int BIT_W = $clog2(WIDTH);

   localparam logic [2:0] ST_IDLE   = TX_IDLE;
   localparam logic [2:0] ST_START  = TX_START;
   localparam logic [2:0] ST_DATA   = TX_DATA;
   localparam logic [2:0] ST_STOP   = TX_STOP;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam logic [2:0] ST_PARITY = TX_PARITY;
`endif

   logic [2:0]        state_q, state_d;
   logic [WIDTH-1:0]  shreg_q, shreg_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              get_q, get_d;
`ifdef FIFO_UART_TX_PARITY_EN
   logic              par_q, par_d;
`endif

   logic [WIDTH-1:0]  head_w;
   logic [SIZE_W-1:0] size_w;
   logic              tick, load;

   assign head_w = rd.fifo_data;
   assign size_w = rd.fifo_size;

   // The STOP->START reload on the final tick is what gives gapless back-to-back frames.
   assign load = enable_i && (size_w != '0) &&
                 ((state_q == ST_IDLE) || ((state_q == ST_STOP) && tick));

   uart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i ((state_q == ST_IDLE) || load),
      .tick_o  (tick)
   );

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      get_d   = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      if (load) begin
         state_d = ST_START;
         shreg_d = head_w;
         bit_d   = '0;
         tx_d    = 1'b0;
         busy_d  = 1'b1;
         get_d   = 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
         par_d   = ^head_w;
`endif
      end else if (tick) begin
         case (state_q)
            ST_START: begin
               state_d = ST_DATA;
               tx_d    = shreg_q[0];
               shreg_d = shreg_q >> 1;
            end
            ST_DATA: begin
               if (bit_q == BIT_W'(WIDTH - 1)) begin
`ifdef FIFO_UART_TX_PARITY_EN
                  state_d = ST_PARITY;
                  tx_d    = par_q;
`else
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_d   = bit_q + 1'b1;
                  tx_d    = shreg_q[0];
                  shreg_d = shreg_q >> 1;
               end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
               state_d = ST_STOP;
               tx_d    = 1'b1;
            end
`endif
            default: begin
               state_d = ST_IDLE;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
               bit_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         get_q   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         get_q   <= get_d;
`ifdef FIFO_UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign tx_o        = tx_q;
   assign busy_o      = busy_q;
   assign rd.fifo_get = get_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench: real 4-deep fifo feeding fifo_uart_tx (CLKS_PER_BIT=4); bytes are scoreboarded and decoded off tx_o.
module tb_fifo_uart_tx;
   localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME_LEN = NBITS * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       fifo_rst_n = 1'b0;
   logic       enable = 1'b1;
   logic [7:0] wr_data = 8'h00;
   logic       wr_put = 1'b0;
   logic       tx, busy;

   int tests_run = 0;
   int tests_failed = 0;
   int get_cnt = 0;
   int bad_get = 0;
   int busy_run = 0;
   int last_busy_len = 0;
   logic [7:0] sb[$];

   always #5 clk = ~clk;

   fifo_uart_tx_if #(.WIDTH(8), .SIZE_W(4)) bus ();

   fifo #(.WIDTH(8), .DEPTH(4), .SIZE_W(4)) u_fifo (
      .clk_i     (clk),
      .rst_i     (fifo_rst_n),
      .data_i    (wr_data),
      .putData_i (wr_put),
      .data_o    (bus.fifo_data),
      .size_o    (bus.fifo_size),
      .getData_i (bus.fifo_get)
   );

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .WIDTH(8), .SIZE_W(4)) dut (
      .clk_i    (clk),
      .rst_i    (rst_n),
      .enable_i (enable),
      .rd       (bus.slave),
      .tx_o     (tx),
      .busy_o   (busy)
   );

   always @(negedge clk) begin
      if (bus.fifo_get === 1'b1) get_cnt <= get_cnt + 1;
      if (bus.fifo_get === 1'b1 && bus.fifo_size == 4'd0) bad_get <= bad_get + 1;
      if (busy === 1'b1) busy_run <= busy_run + 1;
      else if (busy_run != 0) begin
         last_busy_len <= busy_run;
         busy_run <= 0;
      end
   end

   task automatic sync();
      @(posedge clk); #1;
   endtask

   // Leaves wr_put high so consecutive calls write on consecutive edges.
   task automatic put_word(input logic [7:0] b);
      wr_data = b;
      wr_put  = 1'b1;
      sb.push_back(b);
      @(posedge clk); #1;
   endtask

   task automatic rx_frame(input bit aligned, output logic [7:0] b, output logic par,
                           output logic start_bit, output logic stop_bit, output bit ok);
      int n = 0;
      b = 8'h00; par = 1'b0; start_bit = 1'b1; stop_bit = 1'b0; ok = 1'b0;
      if (!aligned) begin
         do begin
            @(negedge clk);
            n++;
         end while (tx !== 1'b0 && n < 400);
         if (tx !== 1'b0) return;
      end
      repeat (CPB / 2) @(negedge clk);
      start_bit = tx;
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(negedge clk);
         b[i] = tx;
      end
`ifdef FIFO_UART_TX_PARITY_EN
      repeat (CPB) @(negedge clk);
      par = tx;
`endif
      repeat (CPB) @(negedge clk);
      stop_bit = tx;
      ok = 1'b1;
   endtask

   task automatic wait_idle(output bit ok);
      int n = 0;
      while (busy !== 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      ok = (busy === 1'b0);
      @(negedge clk);
   endtask

   function automatic logic [7:0] sb_pop();
      logic [7:0] v = 8'hxx;
      if (sb.size() != 0) v = sb.pop_front();
      return v;
   endfunction

   task automatic test_reset();
      int idle_bad = 0;
      repeat (3) @(negedge clk);
      tests_run++; if (tx !== 1'b1) begin tests_failed++; $display("FAIL reset_tx: got %b, expected 1", tx); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, expected 0", busy); end
      tests_run++; if (bus.fifo_get !== 1'b0) begin tests_failed++; $display("FAIL reset_get: got %b, expected 0", bus.fifo_get); end
      sync();
      rst_n = 1'b1;
      fifo_rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) idle_bad++;
      end
      tests_run++; if (idle_bad !== 0) begin tests_failed++; $display("FAIL empty_idle_line: got %0d bad cycles, expected 0", idle_bad); end
      tests_run++; if (get_cnt !== 0) begin tests_failed++; $display("FAIL empty_no_pop: got %0d pops, expected 0", get_cnt); end
   endtask

   task automatic test_single(input logic [7:0] val);
      logic [7:0] b, exp;
      logic par, st, sp;
      bit ok;
      int g0 = get_cnt;
      sync();
      put_word(val);
      wr_put = 1'b0;
      @(negedge clk);
      tests_run++; if (bus.fifo_size !== 4'd1 || tx !== 1'b1) begin tests_failed++; $display("FAIL pre_launch: got size=%0d tx=%b, expected size=1 tx=1", bus.fifo_size, tx); end
      @(negedge clk);
      tests_run++; if (tx !== 1'b0 || busy !== 1'b1 || bus.fifo_get !== 1'b1) begin tests_failed++; $display("FAIL launch_latency: got tx=%b busy=%b get=%b, expected 0 1 1", tx, busy, bus.fifo_get); end
      rx_frame(1'b1, b, par, st, sp, ok);
      exp = sb_pop();
      tests_run++; if (st !== 1'b0) begin tests_failed++; $display("FAIL start_bit_%h: got %b, expected 0", val, st); end
      tests_run++; if (b !== exp) begin tests_failed++; $display("FAIL data_%h: got %h, expected %h", val, b, exp); end
      tests_run++; if (sp !== 1'b1) begin tests_failed++; $display("FAIL stop_bit_%h: got %b, expected 1", val, sp); end
`ifdef FIFO_UART_TX_PARITY_EN
      tests_run++; if (par !== ^exp) begin tests_failed++; $display("FAIL parity_%h: got %b, expected %b", val, par, ^exp); end
`endif
      wait_idle(ok);
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL idle_timeout_%h: got busy=%b, expected 0", val, busy); end
      tests_run++; if (last_busy_len !== FRAME_LEN) begin tests_failed++; $display("FAIL frame_len_%h: got %0d, expected %0d", val, last_busy_len, FRAME_LEN); end
      tests_run++; if (get_cnt - g0 !== 1) begin tests_failed++; $display("FAIL pops_%h: got %0d, expected 1", val, get_cnt - g0); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b, exp;
      logic par, st, sp;
      bit ok;
      int g0 = get_cnt;
      sync();
      put_word(8'h01);
      put_word(8'h02);
      put_word(8'h03);
      wr_put = 1'b0;
      for (int f = 0; f < 3; f++) begin
         rx_frame(1'b0, b, par, st, sp, ok);
         exp = sb_pop();
         tests_run++; if (!ok || b !== exp || st !== 1'b0 || sp !== 1'b1) begin tests_failed++; $display("FAIL b2b_frame%0d: got ok=%b data=%h start=%b stop=%b, expected 1 %h 0 1", f, ok, b, st, sp, exp); end
      end
      wait_idle(ok);
      tests_run++; if (!ok || last_busy_len !== 3 * FRAME_LEN) begin tests_failed++; $display("FAIL b2b_busy_len: got %0d, expected %0d", last_busy_len, 3 * FRAME_LEN); end
      tests_run++; if (get_cnt - g0 !== 3 || bus.fifo_size !== 4'd0) begin tests_failed++; $display("FAIL b2b_pops: got pops=%0d size=%0d, expected 3 0", get_cnt - g0, bus.fifo_size); end
   endtask

   task automatic test_enable();
      logic [7:0] b, exp;
      logic par, st, sp;
      bit ok;
      int g0 = get_cnt;
      sync();
      enable = 1'b0;
      put_word(8'h5A);
      put_word(8'h96);
      wr_put = 1'b0;
      repeat (20) @(negedge clk);
      tests_run++; if (get_cnt - g0 !== 0 || busy !== 1'b0 || tx !== 1'b1) begin tests_failed++; $display("FAIL disabled_hold: got pops=%0d busy=%b tx=%b, expected 0 0 1", get_cnt - g0, busy, tx); end
      sync();
      enable = 1'b1;
      fork
         rx_frame(1'b0, b, par, st, sp, ok);
         begin
            repeat (12) @(posedge clk);
            #1 enable = 1'b0;
         end
      join
      exp = sb_pop();
      tests_run++; if (!ok || b !== exp) begin tests_failed++; $display("FAIL en_frame1: got ok=%b data=%h, expected 1 %h", ok, b, exp); end
      wait_idle(ok);
      repeat (3 * FRAME_LEN) @(negedge clk);
      tests_run++; if (!ok || get_cnt - g0 !== 1 || busy !== 1'b0 || bus.fifo_size !== 4'd1) begin tests_failed++; $display("FAIL en_drop_stops: got pops=%0d busy=%b size=%0d, expected 1 0 1", get_cnt - g0, busy, bus.fifo_size); end
      sync();
      enable = 1'b1;
      rx_frame(1'b0, b, par, st, sp, ok);
      exp = sb_pop();
      tests_run++; if (!ok || b !== exp) begin tests_failed++; $display("FAIL en_frame2: got ok=%b data=%h, expected 1 %h", ok, b, exp); end
      wait_idle(ok);
   endtask

   task automatic test_abort_reset();
      logic [7:0] b, exp;
      logic par, st, sp;
      bit ok;
      int n = 0;
      int g0 = get_cnt;
      sync();
      put_word(8'h3C);
      put_word(8'hC3);
      wr_put = 1'b0;
      while (tx !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      tests_run++; if (tx !== 1'b0) begin tests_failed++; $display("FAIL abort_start: got tx=%b, expected 0", tx); end
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      tests_run++; if (tx !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL abort_async: got tx=%b busy=%b, expected 1 0", tx, busy); end
      repeat (3) sync();
      rst_n = 1'b1;
      void'(sb_pop());
      rx_frame(1'b0, b, par, st, sp, ok);
      exp = sb_pop();
      tests_run++; if (!ok || b !== exp || sp !== 1'b1) begin tests_failed++; $display("FAIL abort_next_word: got ok=%b data=%h stop=%b, expected 1 %h 1", ok, b, sp, exp); end
      wait_idle(ok);
      tests_run++; if (get_cnt - g0 !== 2 || bus.fifo_size !== 4'd0) begin tests_failed++; $display("FAIL abort_pops: got pops=%0d size=%0d, expected 2 0", get_cnt - g0, bus.fifo_size); end
   endtask

   initial begin
      test_reset();
      test_single(8'hA5);
      test_back_to_back();
      test_enable();
      test_abort_reset();
      test_single(8'h07);
      tests_run++; if (bad_get !== 0) begin tests_failed++; $display("FAIL pop_while_empty: got %0d, expected 0", bad_get); end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
